// File: rtl/functw_mc.sv
// functw_mc: multi-channel, pipelined G.726 W(I) lookup with a per-channel rate table.
// Optional illegal-codeword flag/counter is built in when FUNCTW_ILLEGAL_CHK_EN is defined.
module functw_mc #(
    parameter int         NUM_CH   = 4,
    parameter int         CH_W     = 2,
    parameter logic [1:0] RST_RATE = 2'b01,
    parameter int         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_rate,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [4:0]        in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [1:0]        out_rate,
`ifdef FUNCTW_ILLEGAL_CHK_EN
    output logic [11:0]       out_wi,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
`else
    output logic [11:0]       out_wi
`endif
);

    localparam int TBL_SZ = 2 ** CH_W;

    if (NUM_CH < 2 || TBL_SZ < NUM_CH || CNT_W < 1) begin : g_bad_param
        $error("functw_mc: illegal parameter combination");
    end

    logic [1:0]        rate_tbl_q [NUM_CH];
    logic [1:0]        rate_lu    [TBL_SZ];
    logic [TBL_SZ-1:0] ch_ok_v;

    // Channels beyond NUM_CH read back the reset rate and force a zero WI.
    for (genvar g = 0; g < TBL_SZ; g++) begin : g_lu
        if (g < NUM_CH) begin : g_in
            assign rate_lu[g] = rate_tbl_q[g];
            assign ch_ok_v[g] = 1'b1;
        end else begin : g_out
            assign rate_lu[g] = RST_RATE;
            assign ch_ok_v[g] = 1'b0;
        end
    end

    function automatic logic [11:0] wi_lookup(input logic [1:0] rate, input logic [4:0] i);
        logic [3:0]  im;
        logic [11:0] wi;
        im = '0;
        wi = '0;
        case (rate)
            2'b00: begin
                im = i[4] ? ~i[3:0] : i[3:0];
                case (im)
                    4'd0:  wi = 12'h00E;  4'd1:  wi = 12'h00E;
                    4'd2:  wi = 12'h018;  4'd3:  wi = 12'h027;
                    4'd4:  wi = 12'h028;  4'd5:  wi = 12'h029;
                    4'd6:  wi = 12'h03A;  4'd7:  wi = 12'h064;
                    4'd8:  wi = 12'h08D;  4'd9:  wi = 12'h0B3;
                    4'd10: wi = 12'h0DB;  4'd11: wi = 12'h118;
                    4'd12: wi = 12'h166;  4'd13: wi = 12'h1B8;
                    4'd14: wi = 12'h211;  default: wi = 12'h2B8;
                endcase
            end
            2'b01: begin
                im = {1'b0, (i[3] ? ~i[2:0] : i[2:0])};
                case (im[2:0])
                    3'd0: wi = 12'hFF4;  3'd1: wi = 12'h012;
                    3'd2: wi = 12'h029;  3'd3: wi = 12'h040;
                    3'd4: wi = 12'h070;  3'd5: wi = 12'h0C6;
                    3'd6: wi = 12'h163;  default: wi = 12'h462;
                endcase
            end
            2'b10: begin
                im = {2'b00, (i[2] ? ~i[1:0] : i[1:0])};
                case (im[1:0])
                    2'd0: wi = 12'hFFC;  2'd1: wi = 12'h01E;
                    2'd2: wi = 12'h089;  default: wi = 12'h246;
                endcase
            end
            default: begin
                im = {3'b000, (i[1] ? ~i[0] : i[0])};
                wi = im[0] ? 12'h1B7 : 12'hFEA;
            end
        endcase
        return wi;
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [1:0]        out_rate_q,  out_rate_d;
    logic [11:0]       out_wi_q,    out_wi_d;
    logic              accept;
    logic [1:0]        lu_rate;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign lu_rate  = rate_lu[in_ch];

    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_rate_d  = out_rate_q;
        out_wi_d    = out_wi_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_rate_d  = lu_rate;
            out_wi_d    = ch_ok_v[in_ch] ? wi_lookup(lu_rate, in_i) : 12'h000;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Table write lands after this cycle's lookup, so a colliding sample sees the old rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) rate_tbl_q[k] <= RST_RATE;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_rate_q  <= '0;
            out_wi_q    <= '0;
        end else begin
            if (cfg_we) begin
                for (int k = 0; k < NUM_CH; k++)
                    if (cfg_ch == CH_W'(k)) rate_tbl_q[k] <= cfg_rate;
            end
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_rate_q  <= out_rate_d;
            out_wi_q    <= out_wi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_rate  = out_rate_q;
    assign out_wi    = out_wi_q;

`ifdef FUNCTW_ILLEGAL_CHK_EN
    logic             ill;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        case (lu_rate)
            2'b00:   ill = 1'b0;
            2'b01:   ill = in_i[4];
            2'b10:   ill = |in_i[4:3];
            default: ill = |in_i[4:2];
        endcase
        out_err_d = accept ? ill : out_err_q;
        err_cnt_d = err_cnt_q;
        if (accept && ill && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_err = out_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_functw_mc.sv
// Directed testbench for functw_mc: lookups, rate-table writes, collision and backpressure.
module tb_functw_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_rate = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [4:0]  in_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch;
    logic [1:0]  out_rate;
    logic [11:0] out_wi;
`ifdef FUNCTW_ILLEGAL_CHK_EN
    logic        out_err;
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    functw_mc dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_rate(cfg_rate),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_rate(out_rate),
`ifdef FUNCTW_ILLEGAL_CHK_EN
        .out_wi(out_wi), .out_err(out_err), .err_cnt(err_cnt)
`else
        .out_wi(out_wi)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge with out_ready=1; returns at the next negedge with the result registered.
    task automatic send(input logic [1:0] ch, input logic [4:0] i);
        in_valid = 1'b1; in_ch = ch; in_i = i;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp_wi;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_wi !== 12'h000 || out_rate !== 2'b00 || out_ch !== 2'd0)
            begin errors++; $display("FAIL reset_out_regs: got wi=%h rate=%b ch=%0d expected 000/00/0", out_wi, out_rate, out_ch); end
        exp_wi = 12'hFF4;
        for (int c = 0; c < 4; c++) begin
            send(2'(c), 5'h00);
            checks++; if (out_rate !== 2'b01 || out_wi !== exp_wi || out_ch !== 2'(c))
                begin errors++; $display("FAIL reset_first_rate ch%0d: got rate=%b wi=%h ch=%0d expected 01/%h/%0d", c, out_rate, out_wi, out_ch, exp_wi, c); end
        end
    endtask

    task automatic test_lookup_32k();
        logic [4:0]  vi [5];
        logic [11:0] vw [5];
        vi = '{5'h07, 5'h0F, 5'h08, 5'h0C, 5'h04};
        vw = '{12'h462, 12'hFF4, 12'h462, 12'h040, 12'h070};
        for (int k = 0; k < 5; k++) begin
            send(2'd0, vi[k]);
            checks++; if (out_valid !== 1'b1 || out_wi !== vw[k] || out_ch !== 2'd0)
                begin errors++; $display("FAIL lookup32 i=%h: got v=%b wi=%h ch=%0d expected 1/%h/0", vi[k], out_valid, out_wi, out_ch, vw[k]); end
        end
    endtask

    task automatic test_cfg_16k();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_rate = 2'b11;
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        send(2'd2, 5'h01);
        checks++; if (out_wi !== 12'h1B7 || out_rate !== 2'b11 || out_ch !== 2'd2)
            begin errors++; $display("FAIL cfg16_i01: got wi=%h rate=%b ch=%0d expected 1B7/11/2", out_wi, out_rate, out_ch); end
        send(2'd2, 5'h03);
        checks++; if (out_wi !== 12'hFEA)
            begin errors++; $display("FAIL cfg16_i03: got wi=%h expected FEA", out_wi); end
    endtask

    task automatic test_collision();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_rate = 2'b00;
        send(2'd1, 5'h1F);
        cfg_we = 1'b0;
        checks++; if (out_rate !== 2'b01 || out_wi !== 12'hFF4)
            begin errors++; $display("FAIL collision_old_rate: got rate=%b wi=%h expected 01/FF4", out_rate, out_wi); end
        send(2'd1, 5'h1F);
        checks++; if (out_rate !== 2'b00 || out_wi !== 12'h00E)
            begin errors++; $display("FAIL collision_new_rate: got rate=%b wi=%h expected 00/00E", out_rate, out_wi); end
    endtask

    // Rates here: ch0=01, ch1=00, ch2=11, ch3 rewritten to 10 during the stall.
    task automatic test_back_to_back();
        logic [1:0]  ech [4];
        logic [4:0]  ei  [4];
        logic [11:0] ew  [4];
        logic [1:0]  er  [4];
        ech = '{2'd0, 2'd1, 2'd2, 2'd3};
        ei  = '{5'h05, 5'h0A, 5'h02, 5'h06};
        ew  = '{12'h0C6, 12'h0DB, 12'h1B7, 12'h01E};
        er  = '{2'b01, 2'b00, 2'b11, 2'b10};
        out_ready = 1'b1;
        in_valid = 1'b1; in_ch = ech[0]; in_i = ei[0];
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0; in_ch = ech[1]; in_i = ei[1];
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_rate = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_ch !== ech[0] || out_wi !== ew[0] || out_rate !== er[0] || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold cyc%0d: got v=%b ch=%0d wi=%h rate=%b rdy=%b expected 1/0/%h/%b/0", k, out_valid, out_ch, out_wi, out_rate, in_ready, ew[0], er[0]); end
            @(posedge clk); @(negedge clk);
            cfg_we = 1'b0;
        end
        out_ready = 1'b1;
        for (int s = 1; s < 4; s++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_ch !== ech[s] || out_wi !== ew[s] || out_rate !== er[s])
                begin errors++; $display("FAIL stream s%0d: got v=%b ch=%0d wi=%h rate=%b expected 1/%0d/%h/%b", s, out_valid, out_ch, out_wi, out_rate, ech[s], ew[s], er[s]); end
            if (s < 3) begin in_ch = ech[s+1]; in_i = ei[s+1]; end
            else in_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0)
            begin errors++; $display("FAIL stream_drain: got v=%b expected 0", out_valid); end
    endtask

`ifdef FUNCTW_ILLEGAL_CHK_EN
    task automatic test_illegal();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        send(2'd0, 5'h13);
        checks++; if (out_wi !== 12'h040 || out_err !== 1'b1 || err_cnt !== 16'd1)
            begin errors++; $display("FAIL illegal_13: got wi=%h err=%b cnt=%0d expected 040/1/1", out_wi, out_err, err_cnt); end
        send(2'd0, 5'h07);
        checks++; if (out_wi !== 12'h462 || out_err !== 1'b0 || err_cnt !== 16'd1)
            begin errors++; $display("FAIL illegal_legal: got wi=%h err=%b cnt=%0d expected 462/0/1", out_wi, out_err, err_cnt); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        checks++; if (err_cnt !== 16'd0 || out_err !== 1'b0)
            begin errors++; $display("FAIL illegal_reset: got err=%b cnt=%0d expected 0/0", out_err, err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_lookup_32k();
        test_cfg_16k();
        test_collision();
        test_back_to_back();
`ifdef FUNCTW_ILLEGAL_CHK_EN
        test_illegal();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
